// File: rtl/ysyx_23060221_lsu_if.sv
// Bundles every non-clock signal of the load/store unit:
//   upstream  : EXU_valid, LSU_ready, addr, wdata, memop, memrd, memwr
//   memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, mem_ack, mem_rdata
//   writeback : LSU_valid, WBU_ready, res
// Modport slave is the LSU's view (it is the slave of the execute stage);
// modport master is the surrounding pipeline/memory/testbench view.
interface ysyx_23060221_lsu_if;
  logic        EXU_valid;
  logic        LSU_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic        memrd;
  logic        memwr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        LSU_valid;
  logic        WBU_ready;
  logic [31:0] res;

  modport slave (
    input  EXU_valid, addr, wdata, memop, memrd, memwr, mem_ack, mem_rdata, WBU_ready,
    output LSU_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, LSU_valid, res
  );

  modport master (
    output EXU_valid, addr, wdata, memop, memrd, memwr, mem_ack, mem_rdata, WBU_ready,
    input  LSU_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, LSU_valid, res
  );
endinterface

// File: rtl/ysyx_23060221_lsu.sv
// Load/store unit: accepts one execute-stage result at a time, performs an
// optional single memory access (byte/half/word, signed or unsigned loads),
// and presents the result to writeback with a valid/ready handshake.
// Ports: clk, rst (synchronous, active-high), bus (ysyx_23060221_lsu_if.slave).
module ysyx_23060221_lsu (
  input  logic clk,
  input  logic rst,
  ysyx_23060221_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, res_q;
  logic [2:0]  memop_q;
  logic        memrd_q, memwr_q;

  logic        accept;
  logic        is_store;
  logic        sz_byte, sz_half;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] rd_b_sh, rd_h_sh, ld_val;

  logic        lsu_ready, lsu_valid, req, we;
  logic [3:0]  wmask;

  assign accept   = bus.EXU_valid & lsu_ready;
  // A request with both memrd and memwr behaves as a load.
  assign is_store = memwr_q & ~memrd_q;

  // memop[1:0]: 00 byte, 01 half, anything else word; memop[2] = unsigned.
  assign sz_byte = (memop_q[1:0] == 2'b00);
  assign sz_half = (memop_q[1:0] == 2'b01);

  always_comb begin
    st_mask = 4'b1111;
    st_data = wdata_q;
    if (sz_byte) begin
      st_mask = 4'b0001 << addr_q[1:0];
      st_data = wdata_q << {addr_q[1:0], 3'b000};
    end else if (sz_half) begin
      st_mask = 4'b0011 << {addr_q[1], 1'b0};
      st_data = wdata_q << {addr_q[1:0], 3'b000};
    end
  end

  // Lane select for loads; misaligned low address bits are simply dropped.
  assign rd_b_sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign rd_h_sh = bus.mem_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    ld_val = bus.mem_rdata;
    if (sz_byte)
      ld_val = {{24{rd_b_sh[7] & ~memop_q[2]}}, rd_b_sh[7:0]};
    else if (sz_half)
      ld_val = {{16{rd_h_sh[15] & ~memop_q[2]}}, rd_h_sh[15:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      memop_q <= '0;
      memrd_q <= 1'b0;
      memwr_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        memop_q <= bus.memop;
        memrd_q <= bus.memrd;
        memwr_q <= bus.memwr;
        if (!bus.memrd && !bus.memwr) res_q <= bus.addr;
      end
      if (state == REQ && bus.mem_ack)
        res_q <= is_store ? 32'h0 : ld_val;
    end
  end

  always_comb begin
    state_nxt = state;
    lsu_ready = 1'b0;
    lsu_valid = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    wmask     = 4'b0000;
    unique case (state)
      IDLE: begin
        lsu_ready = 1'b1;
        if (bus.EXU_valid)
          state_nxt = (bus.memrd || bus.memwr) ? REQ : DONE;
      end
      REQ: begin
        req   = 1'b1;
        we    = is_store;
        wmask = is_store ? st_mask : 4'b0000;
        if (bus.mem_ack) state_nxt = DONE;
      end
      DONE: begin
        lsu_valid = 1'b1;
        if (bus.WBU_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.LSU_ready = lsu_ready;
  assign bus.LSU_valid = lsu_valid;
  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_wmask = wmask;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = st_data;
  assign bus.res       = res_q;

endmodule
